// File: rtl/i2c_target.sv
// I2C target engine: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// parallel write-byte output and read-byte input. Open-drain SDA only, no clock stretching.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_nx;
    logic [7:0] shift, shift_nx, tx_sh, tx_sh_nx, rx_data_nx;
    logic [2:0] cnt, cnt_nx;
    logic       full, full_nx;
    logic       sda_oe_nx, rx_valid_nx, tx_load_nx, match_nx;

    // Synchronizers preset high so reset release on an idle bus shows no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= 8'h00;
            tx_sh      <= 8'h00;
            cnt        <= 3'd0;
            full       <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_load    <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            tx_sh      <= tx_sh_nx;
            cnt        <= cnt_nx;
            full       <= full_nx;
            sda_oe     <= sda_oe_nx;
            rx_data    <= rx_data_nx;
            rx_valid   <= rx_valid_nx;
            tx_load    <= tx_load_nx;
            addr_match <= match_nx;
        end
    end

    // `full` marks that the 8th rise of a byte has been seen; in RD_ACK it
    // instead records that the controller ACKed.
    always_comb begin
        state_nx    = state;
        shift_nx    = shift;
        tx_sh_nx    = tx_sh;
        cnt_nx      = cnt;
        full_nx     = full;
        sda_oe_nx   = sda_oe;
        rx_data_nx  = rx_data;
        rx_valid_nx = 1'b0;
        tx_load_nx  = 1'b0;
        match_nx    = addr_match;

        if (start_det) begin
            state_nx  = ADDR;
            cnt_nx    = 3'd0;
            full_nx   = 1'b0;
            sda_oe_nx = 1'b0;
            match_nx  = 1'b0;
        end else if (stop_det) begin
            state_nx  = IDLE;
            cnt_nx    = 3'd0;
            full_nx   = 1'b0;
            sda_oe_nx = 1'b0;
            match_nx  = 1'b0;
        end else begin
            if (scl_rise && (state inside {ADDR, WR_DATA, RD_DATA})) begin
                shift_nx = {shift[6:0], sda_s};
                cnt_nx   = cnt + 3'd1;
                if (cnt == 3'd7) full_nx = 1'b1;
            end

            case (state)
                ADDR: if (scl_fall && full) begin
                    full_nx = 1'b0;
                    if (shift[7:1] == TARGET_ADDR) begin
                        sda_oe_nx = 1'b1;
                        match_nx  = 1'b1;
                        state_nx  = ADDR_ACK;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    cnt_nx  = 3'd0;
                    full_nx = 1'b0;
                    if (!shift[0]) begin
                        sda_oe_nx = 1'b0;
                        state_nx  = WR_DATA;
                    end else begin
                        tx_sh_nx   = tx_data;
                        tx_load_nx = 1'b1;
                        sda_oe_nx  = ~tx_data[7];
                        state_nx   = RD_DATA;
                    end
                end
                WR_DATA: if (scl_fall && full) begin
                    full_nx     = 1'b0;
                    rx_data_nx  = shift;
                    rx_valid_nx = 1'b1;
                    sda_oe_nx   = 1'b1;
                    state_nx    = WR_ACK;
                end
                WR_ACK: if (scl_fall) begin
                    cnt_nx    = 3'd0;
                    full_nx   = 1'b0;
                    sda_oe_nx = 1'b0;
                    state_nx  = WR_DATA;
                end
                RD_DATA: if (scl_fall) begin
                    if (full) begin
                        full_nx   = 1'b0;
                        cnt_nx    = 3'd0;
                        sda_oe_nx = 1'b0;
                        state_nx  = RD_ACK;
                    end else begin
                        tx_sh_nx  = {tx_sh[6:0], 1'b0};
                        sda_oe_nx = ~tx_sh[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_nx = IDLE;
                        else       full_nx  = 1'b1;
                    end else if (scl_fall && full) begin
                        full_nx    = 1'b0;
                        cnt_nx     = 3'd0;
                        tx_sh_nx   = tx_data;
                        tx_load_nx = 1'b1;
                        sda_oe_nx  = ~tx_data[7];
                        state_nx   = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller model, rx_valid scoreboard
// monitor, and directed write/read/abort/reset scenarios.
module tb_i2c_target;

    localparam int Q = 4;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset;
    logic       scl, sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       addr_match;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;
    int oe_cnt   = 0;
    logic [7:0] exp_rx[$];

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .addr_match (addr_match),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got %02h with no byte expected", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_data", {24'h0, rx_data}, {24'h0, e});
                end
            end
            if (tx_load) tx_cnt++;
            if (sda_oe)  oe_cnt++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered and left with SCL low; returns SDA sampled mid-high.
    task automatic send_bit(input logic b, output logic rd);
        wait_clk(Q); sda_m = b;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); rd = sda_bus;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic start_idle();
        sda_m = 1'b0; wait_clk(Q); scl = 1'b0;
    endtask

    task automatic start_rep();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(d[i], r);
        send_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, r);
            d[i] = r;
        end
        tx_data = next_tx;
        send_bit(ack_bit, r);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, r;
        logic [7:0] d;
        int         snap_rx, snap_tx, snap_oe;

        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        fork monitor(); join_none
        wait_clk(4);
        chk("rst_sda_oe",     {31'h0, sda_oe},     32'h0);
        chk("rst_rx_data",    {24'h0, rx_data},    32'h0);
        chk("rst_rx_valid",   {31'h0, rx_valid},   32'h0);
        chk("rst_tx_load",    {31'h0, tx_load},    32'h0);
        chk("rst_addr_match", {31'h0, addr_match}, 32'h0);
        chk("rst_busy",       {31'h0, busy},       32'h0);
        reset = 1'b0;
        wait_clk(8);

        // Write 0xA0, 0x3C, 0xFF
        start_idle();
        chk("wr_busy_after_start", {31'h0, busy}, 32'h1);
        wr_byte(8'hA0, ack);
        chk("wr_addr_ack", {31'h0, ack}, 32'h0);
        chk("wr_addr_match", {31'h0, addr_match}, 32'h1);
        exp_rx.push_back(8'h3C);
        wr_byte(8'h3C, ack);
        chk("wr_d0_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'hFF);
        wr_byte(8'hFF, ack);
        chk("wr_d1_ack", {31'h0, ack}, 32'h0);
        stop_cond();
        wait_clk(4);
        chk("wr_busy_after_stop", {31'h0, busy}, 32'h0);
        chk("wr_match_after_stop", {31'h0, addr_match}, 32'h0);
        chk("wr_rx_count", rx_cnt, 32'd2);

        // Wrong address 0x51: never driven
        snap_oe = oe_cnt; snap_rx = rx_cnt;
        start_idle();
        wr_byte(8'hA2, ack);
        chk("bad_addr_nack", {31'h0, ack}, 32'h1);
        chk("bad_addr_match", {31'h0, addr_match}, 32'h0);
        wr_byte(8'h12, ack);
        chk("bad_data_nack", {31'h0, ack}, 32'h1);
        stop_cond();
        wait_clk(4);
        chk("bad_oe_cycles", oe_cnt - snap_oe, 32'd0);
        chk("bad_rx_count", rx_cnt - snap_rx, 32'd0);

        // Read 0x96 (ACK) then 0x5A (NACK)
        snap_tx = tx_cnt;
        tx_data = 8'h96;
        start_idle();
        wr_byte(8'hA1, ack);
        chk("rd_addr_ack", {31'h0, ack}, 32'h0);
        rd_byte(1'b0, 8'h5A, d);
        chk("rd_byte0", {24'h0, d}, 32'h96);
        rd_byte(1'b1, 8'h00, d);
        chk("rd_byte1", {24'h0, d}, 32'h5A);
        wait_clk(2);
        chk("rd_busy_after_nack", {31'h0, busy}, 32'h0);
        chk("rd_oe_after_nack", {31'h0, sda_oe}, 32'h0);
        chk("rd_tx_loads", tx_cnt - snap_tx, 32'd2);
        stop_cond();
        wait_clk(4);

        // Write 0x01, repeated START, read one byte
        snap_rx = rx_cnt;
        start_idle();
        wr_byte(8'hA0, ack);
        chk("rs_wr_addr_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h01);
        wr_byte(8'h01, ack);
        chk("rs_wr_data_ack", {31'h0, ack}, 32'h0);
        start_rep();
        chk("rs_match_cleared", {31'h0, addr_match}, 32'h0);
        snap_tx = tx_cnt;
        tx_data = 8'hC3;
        wr_byte(8'hA1, ack);
        chk("rs_rd_addr_ack", {31'h0, ack}, 32'h0);
        rd_byte(1'b1, 8'h00, d);
        chk("rs_rd_byte", {24'h0, d}, 32'hC3);
        chk("rs_tx_loads", tx_cnt - snap_tx, 32'd1);
        stop_cond();
        wait_clk(4);
        chk("rs_rx_count", rx_cnt - snap_rx, 32'd1);

        // STOP after 4 bits of a data byte
        snap_rx = rx_cnt;
        start_idle();
        wr_byte(8'hA0, ack);
        chk("ab_addr_ack", {31'h0, ack}, 32'h0);
        send_bit(1'b1, r); send_bit(1'b0, r); send_bit(1'b1, r); send_bit(1'b1, r);
        stop_cond();
        wait_clk(4);
        chk("ab_busy", {31'h0, busy}, 32'h0);
        chk("ab_sda_oe", {31'h0, sda_oe}, 32'h0);
        chk("ab_rx_count", rx_cnt - snap_rx, 32'd0);

        // Reset while the target holds the address ACK
        start_idle();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i), r);
        wait_clk(Q);
        chk("rr_oe_before_reset", {31'h0, sda_oe}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rr_oe_in_reset", {31'h0, sda_oe}, 32'h0);
        chk("rr_busy_in_reset", {31'h0, busy}, 32'h0);
        wait_clk(2);
        scl = 1'b1; sda_m = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(8);
        start_idle();
        wr_byte(8'hA0, ack);
        chk("rr_addr_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h77);
        wr_byte(8'h77, ack);
        chk("rr_data_ack", {31'h0, ack}, 32'h0);
        stop_cond();
        wait_clk(4);
        chk("rr_busy_after_stop", {31'h0, busy}, 32'h0);

        chk("rx_queue_drained", exp_rx.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) engine: the responder end of the bus driven by our I2C controller datapath.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, receives write bytes onto a parallel interface, and serves read bytes from a parallel interface.
- Drives SDA open-drain only; never drives SCL (no clock stretching).

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, flip-flop stages on each of scl_in and sda_in (minimum 2).

Ports:
- clk  input  1  system clock; at least 8x the SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw bus SCL level.
- sda_in  input  1  raw bus SDA level.
- sda_oe  output  1  1 = pull SDA low; 0 = release (pad is open-drain).
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- tx_data  input  8  byte to send in a read transfer; sampled when tx_load is high.
- tx_load  output  1  one-cycle pulse when tx_data is captured into the shift register.
- addr_match  output  1  high from address ACK until the next START or STOP.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (reset).
- On reset: state IDLE; sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, addr_match=0, busy=0; synchronizers preset to 1.
- Synchronization: both bus inputs pass through SYNC_STAGES flops, then a further registered copy. Edges are detected from the synced value versus the registered copy.
  - scl_rise / scl_fall come from the synced SCL.
  - START = synced SDA falls while synced SCL is high.
  - STOP = synced SDA rises while synced SCL is high.
- Priority: START and STOP take priority over bit processing in the same cycle.
  - START from any state (repeated START included): go to ADDR, clear bit counter, sda_oe=0, addr_match=0.
  - STOP from any state: go to IDLE, sda_oe=0, addr_match=0.
- Bit timing:
  - Incoming bits are sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall, so the target never creates a false START/STOP.
- IDLE: ignores everything except START.
- ADDR: shifts in 8 bits (7 address bits, then R/W). On the scl_fall after the 8th rise:
  - If shift[7:1]==TARGET_ADDR: sda_oe=1, addr_match=1, go to ADDR_ACK.
  - Otherwise: go to IDLE (sda never driven).
- ADDR_ACK: on the next scl_fall:
  - R/W=0: sda_oe=0, go to WR_DATA.
  - R/W=1: capture tx_data, pulse tx_load, sda_oe=~tx_data[7], go to RD_DATA.
- WR_DATA: shifts 8 bits. On the scl_fall after the 8th rise: rx_data=shift, rx_valid pulses for 1 clk, sda_oe=1, go to WR_ACK.
- WR_ACK: on the next scl_fall: sda_oe=0, counter cleared, go to WR_DATA. Unlimited bytes are accepted.
- RD_DATA: on each scl_fall after bits 7..1, drive the next lower bit (sda_oe = ~bit). On the scl_fall after bit 0's rise: sda_oe=0, go to RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): on the next scl_fall, capture tx_data, pulse tx_load, drive bit 7, go to RD_DATA.
  - 1 (NACK): go to IDLE, keep sda_oe=0, wait for STOP/START.
- Bit counter is 3-bit, wraps 7->0, and is cleared on START and on each ACK-phase exit.
- Reset asserted mid-transfer: outputs return to reset values immediately; bus is released at once.
- A transfer aborted by START/STOP mid-byte discards the partial byte; no rx_valid is raised.

Test Plan:
- Write 0xA0 (addr 0x50, W), data 0x3C, 0xFF, STOP -> ACK low on 9th clock of each byte; rx_valid pulses twice with rx_data 0x3C then 0xFF; busy=0 after STOP.
- Address 0x51 W with data 0x12 -> sda_oe stays 0 for the whole transfer, no rx_valid, addr_match=0.
- Read 0xA1, tx_data=0x96, controller ACKs then NACKs with tx_data=0x5A -> SDA bits 1001_0110 then 0101_1010; exactly 2 tx_load pulses; IDLE after NACK.
- Write 0xA0, data 0x01, repeated START, 0xA1, read one byte NACK -> rx_valid once (0x01); after repeated START, tx_load once and bits match tx_data.
- STOP injected after 4 bits of a write byte -> state IDLE, sda_oe=0, no rx_valid.
- reset asserted while sda_oe=1 during ACK -> sda_oe=0 in the same cycle; busy=0; the next full write transfer succeeds.
